data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Responder (memory) end of the CPU data-memory request/response protocol.
- Accepts one load/store request at a time from the CPU-side initiator and models a fixed, parameterised access latency.
- Applies byte-strobed writes to internal word storage and returns read data or an error.
- Replaces the zero-latency data memory in simulation SoCs so the pipeline's stall handling is exercised.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words of storage (power of two).
- WAIT_CYCLES, 2, extra cycles between request accept and response valid (0..15).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, lane-aligned.
- req_wstrb  input  4  byte-lane write enables; ignored for loads.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  initiator accepts response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  access error (misaligned or out of range).

Behaviour:
- Reset: clk and reset are the only clock/reset; reset is asynchronous, active-low. While reset = 0: state IDLE, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0. Storage contents are not reset.
- FSM: three states, IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1 from the first clk edge after reset deasserts.
  - Accept = req_valid && req_ready at a rising edge. On accept, latch we, addr, wdata, wstrb.
  - Next state is RESP if WAIT_CYCLES = 0, else WAIT with the counter loaded to WAIT_CYCLES-1.
- WAIT:
  - req_ready = 0.
  - Counter decrements each cycle; when it is 0, go to RESP.
- Commit, on the edge entering RESP:
  - Error check: idx = (addr - BASE_ADDR) >> 2. Error if addr[1:0] != 0 or idx >= DEPTH_WORDS.
  - On error: no storage change, rsp_err = 1, rsp_rdata = 0.
  - Load: rsp_rdata = mem[idx].
  - Store: each lane i with wstrb[i] = 1 writes wdata[8i+7:8i]; rsp_rdata = 0.
  - Store with wstrb = 0 is legal: no change, rsp_err = 0.
- Latency: rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accept edge.
- RESP:
  - rsp_valid = 1 and req_ready = 0.
  - rsp_rdata and rsp_err are held stable while rsp_valid && !rsp_ready (backpressure of any length).
  - On rsp_valid && rsp_ready, go to IDLE and clear rsp_valid, rsp_rdata and rsp_err.
  - req_ready returns the following cycle, so there is one idle bubble per transaction and never two outstanding requests.
- Request inputs are ignored outside the IDLE accept edge; a changing req_addr during WAIT has no effect.
- Reset mid-operation:
  - An assertion in WAIT drops the transaction; a store is not committed.
  - An assertion in RESP drops the response; a store that already committed stays.
- Read-after-write: a load accepted after a store's response handshake observes the stored data.

Decomposition:
- Package dmem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - WORD_BYTES = 4;
  - the request struct {we, addr, wdata, wstrb};
  - the response struct {rdata, err}.
- One sub-module, dmem_storage: synchronous word array with a 4-lane byte write enable, one read/write port, and a combinational read at the commit edge. It holds no FSM logic.

Test Plan:
- Store 32'hDEADBEEF, wstrb 4'hF, to 0x10, then load 0x10 with WAIT_CYCLES=2 -> each rsp_valid asserts 3 cycles after its accept; load rdata = 32'hDEADBEEF, err = 0.
- Store 32'h0000AA00, wstrb 4'b0010, to 0x10 over the prior word, then load -> rdata = 32'hDEADAAEF.
- Load 0x13 (misaligned), and load BASE_ADDR+4*DEPTH_WORDS (out of range) -> rsp_err = 1, rdata = 0; a preceding store with the same bad address leaves all memory unchanged.
- Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid, rdata and err stay constant and req_ready stays 0; release -> IDLE, req_ready = 1 one cycle later.
- Build with WAIT_CYCLES=0 and issue back-to-back requests with req_valid held high -> one accept every 3 cycles (accept, RESP, bubble) when rsp_ready is held high.
- Accept store 32'h12345678 to 0x20, pull reset low during WAIT, release, load 0x20 -> the old value is returned, and rsp_valid went 0 asynchronously on reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the latency-modelling data memory responder.
package dmem_pkg;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned IDX_W      = ADDR_W - 2;
   localparam int unsigned CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

   typedef struct packed {
      logic                  we;
      logic [ADDR_W-1:0]     addr;
      logic [DATA_W-1:0]     wdata;
      logic [WORD_BYTES-1:0] wstrb;
   } req_t;

   typedef struct packed {
      logic [DATA_W-1:0] rdata;
      logic              err;
   } rsp_t;

   // Word index of a byte address relative to the mapped base; wraps for addresses below base.
   function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_W-1:0] addr,
                                                    input logic [ADDR_W-1:0] base);
      return IDX_W'((addr - base) >> 2);
   endfunction

endpackage

// File: rtl/dmem_storage.sv
// Word storage with per-byte write enables; read is combinational so the
// commit edge can capture load data in the same cycle it is addressed.
module dmem_storage
   import dmem_pkg::*;
#(
   parameter int unsigned  DEPTH_WORDS = 1024,
   localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input  logic                  clk,
   input  logic [WORD_BYTES-1:0] we_i,
   input  logic [AW-1:0]         addr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   output logic [DATA_W-1:0]     rdata_o_c
);

   logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

   // Contents are intentionally not reset.
   always_ff @(posedge clk) begin
      for (int unsigned b = 0; b < WORD_BYTES; b++) begin
         if (we_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o_c = mem_q[addr_i];

endmodule

// File: rtl/data_memory_responder.sv
// Responder end of the CPU data-memory protocol: one request at a time,
// fixed access latency, byte-strobed stores and error reporting.
module data_memory_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   req_t                  req_q, req_d;
   rsp_t                  rsp_q, rsp_d;
   logic                  ready_q, ready_d;
   logic                  valid_q, valid_d;

   req_t                  cmd;
   rsp_t                  result;
   logic                  commit;
   logic                  acc_err;
   logic [IDX_W-1:0]      idx;
   logic [WORD_BYTES-1:0] mem_we;
   logic [DATA_W-1:0]     mem_rdata;

   // With zero wait cycles the commit happens on the accept edge, so the
   // live request is used in IDLE and the latched one afterwards.
   always_comb begin
      cmd = req_q;
      if (state_q == IDLE) begin
         cmd.we    = req_we;
         cmd.addr  = req_addr;
         cmd.wdata = req_wdata;
         cmd.wstrb = req_wstrb;
      end
   end

   assign idx     = word_index(cmd.addr, BASE_ADDR);
   assign acc_err = (cmd.addr[1:0] != 2'b00) || (idx >= IDX_W'(DEPTH_WORDS));
   assign mem_we  = (commit && cmd.we && !acc_err) ? cmd.wstrb : '0;

   always_comb begin
      result.err   = acc_err;
      result.rdata = (acc_err || cmd.we) ? '0 : mem_rdata;
   end

   dmem_storage #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_storage (
      .clk       (clk),
      .we_i      (mem_we),
      .addr_i    (idx[AW-1:0]),
      .wdata_i   (cmd.wdata),
      .rdata_o_c (mem_rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      rsp_d   = rsp_q;
      ready_d = ready_q;
      valid_d = valid_q;
      commit  = 1'b0;
      unique case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (req_valid && ready_q) begin
               req_d   = cmd;
               ready_d = 1'b0;
               if (WAIT_CYCLES == 0) begin
                  commit  = 1'b1;
                  state_d = RESP;
                  valid_d = 1'b1;
                  rsp_d   = result;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(WAIT_CYCLES - 1);
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               commit  = 1'b1;
               state_d = RESP;
               valid_d = 1'b1;
               rsp_d   = result;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
               valid_d = 1'b0;
               rsp_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         rsp_q   <= '0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         rsp_q   <= rsp_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = valid_q;
   assign rsp_rdata = rsp_q.rdata;
   assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench: instance A (WAIT_CYCLES=2, 1024 words, base 0) and
// instance B (WAIT_CYCLES=0, 16 words, base 0x100).
module tb_data_memory_responder;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
   logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
   logic [3:0]  a_req_wstrb;
   logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
   logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
   logic [3:0]  b_req_wstrb;

   int checks = 0;
   int errors = 0;

   data_memory_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_a (
      .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
      .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
      .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err));

   data_memory_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h100)) u_b (
      .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input bit sel, input logic v, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] st);
      if (sel) begin
         b_req_valid = v; b_req_we = we; b_req_addr = addr; b_req_wdata = wd; b_req_wstrb = st;
      end else begin
         a_req_valid = v; a_req_we = we; a_req_addr = addr; a_req_wdata = wd; a_req_wstrb = st;
      end
   endtask

   // Full transaction with rsp_ready high; returns response, latency and req_ready in the bubble.
   task automatic txn(input bit sel, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rdata, output logic err,
                      output int lat, output logic bubble_ready);
      int n = 0;
      while (!(sel ? b_req_ready : a_req_ready) && n < 20) begin step(); n++; end
      if (n >= 20) begin
         checks++; errors++;
         $display("FAIL txn_ready_timeout: req_ready low for %0d cycles, required high", n);
      end
      set_req(sel, 1'b1, we, addr, wd, st);
      step();
      set_req(sel, 1'b0, 1'b1, 32'hFFFF_FFF1, 32'hA5A5_A5A5, 4'hF);
      lat = 1;
      while (!(sel ? b_rsp_valid : a_rsp_valid) && lat < 20) begin step(); lat++; end
      if (lat >= 20) begin
         checks++; errors++;
         $display("FAIL txn_rsp_timeout: rsp_valid low for %0d cycles, required high", lat);
      end
      rdata = sel ? b_rsp_rdata : a_rsp_rdata;
      err   = sel ? b_rsp_err : a_rsp_err;
      step();
      bubble_ready = sel ? b_req_ready : a_req_ready;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      a_rsp_ready = 1'b1;
      b_rsp_ready = 1'b1;
      repeat (3) step();
      checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b expected 0", a_req_ready); end
      checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", a_rsp_valid); end
      checks++; if (a_rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata: got %h expected 0", a_rsp_rdata); end
      checks++; if (a_rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b expected 0", a_rsp_err); end
      reset = 1'b1;
      step();
      checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after_a: got %b expected 1", a_req_ready); end
      checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after_b: got %b expected 1", b_req_ready); end
   endtask

   task automatic test_store_load();
      logic [31:0] rd; logic er; int lat; logic br;
      txn(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat, br);
      checks++; if (lat !== 3) begin errors++; $display("FAIL st_latency: got %0d expected 3", lat); end
      checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL st_rsp: got err=%b rdata=%h expected err=0 rdata=0", er, rd); end
      checks++; if (br !== 1'b0) begin errors++; $display("FAIL st_bubble: got req_ready=%b expected 0", br); end
      txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, br);
      checks++; if (lat !== 3) begin errors++; $display("FAIL ld_latency: got %0d expected 3", lat); end
      checks++; if (er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_data: got err=%b rdata=%h expected err=0 rdata=deadbeef", er, rd); end
   endtask

   task automatic test_partial_strobe();
      logic [31:0] rd; logic er; int lat; logic br;
      txn(1'b0, 1'b1, 32'h10, 32'h0000_AA00, 4'b0010, rd, er, lat, br);
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL strb_st_err: got %b expected 0", er); end
      txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, br);
      checks++; if (rd !== 32'hDEAD_AAEF) begin errors++; $display("FAIL strb_ld: got %h expected deadaaef", rd); end
      txn(1'b0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, rd, er, lat, br);
      checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL strb0_st: got err=%b rdata=%h expected err=0 rdata=0", er, rd); end
      txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, br);
      checks++; if (rd !== 32'hDEAD_AAEF) begin errors++; $display("FAIL strb0_ld: got %h expected deadaaef", rd); end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic er; int lat; logic br;
      txn(1'b0, 1'b1, 32'h0, 32'h1111_1111, 4'hF, rd, er, lat, br);
      txn(1'b0, 1'b1, 32'h13, 32'hFFFF_FFFF, 4'hF, rd, er, lat, br);
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL mis_st: got err=%b rdata=%h expected err=1 rdata=0", er, rd); end
      txn(1'b0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, rd, er, lat, br);
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL oor_st: got err=%b rdata=%h expected err=1 rdata=0", er, rd); end
      txn(1'b0, 1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat, br);
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL mis_ld: got err=%b rdata=%h expected err=1 rdata=0", er, rd); end
      txn(1'b0, 1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat, br);
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL oor_ld: got err=%b rdata=%h expected err=1 rdata=0", er, rd); end
      txn(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, rd, er, lat, br);
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL top_ld: got err=%b rdata=%h expected err=1 rdata=0", er, rd); end
      txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, br);
      checks++; if (er !== 1'b0 || rd !== 32'hDEAD_AAEF) begin errors++; $display("FAIL mis_noclobber: got err=%b rdata=%h expected err=0 rdata=deadaaef", er, rd); end
      txn(1'b0, 1'b1, 32'hFFC, 32'h0BAD_F00D, 4'hF, rd, er, lat, br);
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL last_st_err: got %b expected 0", er); end
      txn(1'b0, 1'b0, 32'hFFC, 32'h0, 4'h0, rd, er, lat, br);
      checks++; if (er !== 1'b0 || rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL last_ld: got err=%b rdata=%h expected err=0 rdata=0badf00d", er, rd); end
      txn(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, br);
      checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL oor_noclobber: got %h expected 11111111", rd); end
   endtask

   task automatic test_backpressure();
      int n = 0;
      a_rsp_ready = 1'b0;
      set_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      step();
      set_req(1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 4'h0);
      while (!a_rsp_valid && n < 20) begin step(); n++; end
      checks++; if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'hDEAD_AAEF) begin
         errors++; $display("FAIL bp_first: got valid=%b rdata=%h expected valid=1 rdata=deadaaef", a_rsp_valid, a_rsp_rdata);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'hDEAD_AAEF || a_rsp_err !== 1'b0 || a_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: got valid=%b rdata=%h err=%b ready=%b expected 1 deadaaef 0 0",
                     i, a_rsp_valid, a_rsp_rdata, a_rsp_err, a_req_ready);
         end
      end
      a_rsp_ready = 1'b1;
      step();
      checks++; if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b0 || a_rsp_rdata !== 32'h0) begin
         errors++; $display("FAIL bp_release: got valid=%b ready=%b rdata=%h expected 0 0 0", a_rsp_valid, a_req_ready, a_rsp_rdata);
      end
      step();
      checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b expected 1", a_req_ready); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic er; int lat; logic br;
      int n = 0;
      txn(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, rd, er, lat, br);
      set_req(1'b0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 4'hF);
      step();
      set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      step();
      reset = 1'b0;
      #1;
      checks++; if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b0) begin
         errors++; $display("FAIL rstwait_out: got valid=%b ready=%b expected 0 0", a_rsp_valid, a_req_ready);
      end
      step(); step();
      reset = 1'b1;
      step();
      checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL rstwait_ready: got %b expected 1", a_req_ready); end
      txn(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, br);
      checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL rstwait_nocommit: got %h expected cafef00d", rd); end
      // Drop a response already committed.
      a_rsp_ready = 1'b0;
      set_req(1'b0, 1'b1, 1'b1, 32'h24, 32'h55AA_55AA, 4'hF);
      step();
      set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      while (!a_rsp_valid && n < 20) begin step(); n++; end
      #2;
      reset = 1'b0;
      #1;
      checks++; if (a_rsp_valid !== 1'b0 || a_rsp_err !== 1'b0 || a_rsp_rdata !== 32'h0) begin
         errors++; $display("FAIL rstresp_async: got valid=%b err=%b rdata=%h expected 0 0 0", a_rsp_valid, a_rsp_err, a_rsp_rdata);
      end
      a_rsp_ready = 1'b1;
      step();
      reset = 1'b1;
      step(); step();
      txn(1'b0, 1'b0, 32'h24, 32'h0, 4'h0, rd, er, lat, br);
      checks++; if (rd !== 32'h55AA_55AA) begin errors++; $display("FAIL rstresp_kept: got %h expected 55aa55aa", rd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic er; int lat; logic br; logic rdy;
      int k = 0;
      int last = 0;
      set_req(1'b1, 1'b1, 1'b1, 32'h100, 32'hB0B0_0000, 4'hF);
      for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
         rdy = b_req_ready;
         step();
         if (rdy) begin
            checks++; if (b_rsp_valid !== 1'b1 || b_rsp_err !== 1'b0) begin
               errors++; $display("FAIL b2b_rsp%0d: got valid=%b err=%b expected 1 0", k, b_rsp_valid, b_rsp_err);
            end
            if (k > 0) begin
               checks++; if (cyc - last !== 3) begin errors++; $display("FAIL b2b_gap%0d: got %0d expected 3", k, cyc - last); end
            end
            last = cyc;
            k++;
            set_req(1'b1, 1'b1, 1'b1, 32'h100 + 32'(4 * k), 32'hB0B0_0000 + 32'(k), 4'hF);
         end
      end
      set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      checks++; if (k !== 4) begin errors++; $display("FAIL b2b_count: got %0d accepts expected 4", k); end
      step(); step();
      for (int i = 0; i < 4; i++) begin
         txn(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'h0, rd, er, lat, br);
         checks++; if (rd !== 32'hB0B0_0000 + 32'(i) || er !== 1'b0 || lat !== 1) begin
            errors++; $display("FAIL b2b_ld%0d: got rdata=%h err=%b lat=%0d expected %h 0 1", i, rd, er, lat, 32'hB0B0_0000 + 32'(i));
         end
      end
      txn(1'b1, 1'b0, 32'h140, 32'h0, 4'h0, rd, er, lat, br);
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL b_oor_hi: got err=%b rdata=%h expected 1 0", er, rd); end
      txn(1'b1, 1'b0, 32'hFC, 32'h0, 4'h0, rd, er, lat, br);
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL b_oor_lo: got err=%b rdata=%h expected 1 0", er, rd); end
      txn(1'b1, 1'b1, 32'h13C, 32'h0000_7777, 4'hF, rd, er, lat, br);
      txn(1'b1, 1'b0, 32'h13C, 32'h0, 4'h0, rd, er, lat, br);
      checks++; if (er !== 1'b0 || rd !== 32'h0000_7777) begin errors++; $display("FAIL b_last: got err=%b rdata=%h expected 0 00007777", er, rd); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      test_reset();
      test_store_load();
      test_partial_strobe();
      test_errors();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
